// File: rtl/leon_dmem_responder_if.sv
// ============================================================================
// leon_dmem_responder_if : core data-memory request/response bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface leon_dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_data;
  logic        hold;
  logic        mds;
  logic        mexc;
  logic        werr;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  rsp_data, hold, mds, mexc, werr
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output rsp_data, hold, mds, mexc, werr
  );
endinterface

`default_nettype wire

// File: rtl/leon_dmem_responder.sv
// ============================================================================
// leon_dmem_responder : wait-stated data memory model answering the core bus
// Rev 1.0
// ============================================================================
`default_nettype none

module leon_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  leon_dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_hold;
  logic        r_mds;
  logic        r_mexc;
  logic        r_werr;
  logic [31:0] r_rsp_data;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    logic oor;
    logic mis;
    oor = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    return oor || mis;
  endfunction

  // Response source is the live request when entering RESP straight from IDLE
  logic          w_src_write;
  logic [1:0]    w_src_size;
  logic [31:0]   w_src_addr;
  logic          w_src_err;
  logic [AW-1:0] w_src_idx;
  logic [31:0]   w_load_word;

  assign w_src_write = (r_state == IDLE) ? bus.req_write : r_write;
  assign w_src_size  = (r_state == IDLE) ? bus.req_size  : r_size;
  assign w_src_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_src_err   = access_err(w_src_size, w_src_addr);
  assign w_src_idx   = w_src_addr[AW+1:2];
  assign w_load_word = mem[w_src_idx];

  logic          w_cap_err;
  logic [AW-1:0] w_cap_idx;
  logic [31:0]   w_lane_mask;
  logic [31:0]   w_lane_data;
  logic          w_mem_we;

  assign w_cap_err = access_err(r_size, r_addr);
  assign w_cap_idx = r_addr[AW+1:2];
  assign w_mem_we  = !rst && (r_state == RESP) && r_write && !w_cap_err;

  // Big-endian lanes: byte 0 of the word is bits 31:24
  always_comb begin
    w_lane_mask = 32'hFFFF_FFFF;
    w_lane_data = r_wdata;
    case (r_size)
      2'b00: begin
        w_lane_mask = 32'hFF00_0000 >> {r_addr[1:0], 3'b000};
        w_lane_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_mask = r_addr[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_cap_idx] <= (mem[w_cap_idx] & ~w_lane_mask) | (w_lane_data & w_lane_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_hold     <= 1'b1;
      r_mds      <= 1'b1;
      r_mexc     <= 1'b0;
      r_werr     <= 1'b0;
      r_rsp_data <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hold     <= 1'b1;
          r_mds      <= 1'b1;
          r_mexc     <= 1'b0;
          r_werr     <= 1'b0;
          r_rsp_data <= 32'd0;
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              r_state    <= RESP;
              r_mds      <= 1'b0;
              r_mexc     <= w_src_err;
              r_werr     <= w_src_err && w_src_write;
              r_rsp_data <= (w_src_err || w_src_write) ? 32'd0 : w_load_word;
            end else begin
              r_state <= WAIT;
              r_hold  <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state    <= RESP;
            r_cnt      <= 4'd0;
            r_hold     <= 1'b1;
            r_mds      <= 1'b0;
            r_mexc     <= w_src_err;
            r_werr     <= w_src_err && w_src_write;
            r_rsp_data <= (w_src_err || w_src_write) ? 32'd0 : w_load_word;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_hold     <= 1'b1;
          r_mds      <= 1'b1;
          r_mexc     <= 1'b0;
          r_werr     <= 1'b0;
          r_rsp_data <= 32'd0;
        end
        default: begin
          r_state <= IDLE;
          r_hold  <= 1'b1;
          r_mds   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.hold     = r_hold;
  assign bus.mds      = r_mds;
  assign bus.mexc     = r_mexc;
  assign bus.werr     = r_werr;
  assign bus.rsp_data = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_leon_dmem_responder.sv
// ============================================================================
// tb_leon_dmem_responder : directed checks of the data memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_leon_dmem_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  leon_dmem_responder_if bus0 ();
  leon_dmem_responder_if bus1 ();

  leon_dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  leon_dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on dut0; returns response fields, latency and stall count
  task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] data,
                        output logic mexc, output logic werr,
                        output int lat, output int holds);
    @(posedge clk); #1;
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_size  = sz;
    bus0.req_addr  = addr;
    bus0.req_wdata = wd;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    lat   = 1;
    holds = 0;
    while (bus0.mds !== 1'b0 && lat < 40) begin
      if (bus0.hold === 1'b0) holds++;
      @(posedge clk); #1;
      lat++;
    end
    data = bus0.rsp_data;
    mexc = bus0.mexc;
    werr = bus0.werr;
  endtask

  logic [31:0] d;
  logic        mx;
  logic        we;
  int          lat;
  int          hc;
  int          pulses;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'b00;
    bus0.req_addr  = 32'd0; bus0.req_wdata = 32'd0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_size = 2'b10;
    bus1.req_addr  = 32'd0; bus1.req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", 32'(bus0.hold), 32'd1);
    check("rst_mds",  32'(bus0.mds),  32'd1);
    check("rst_mexc", 32'(bus0.mexc), 32'd0);
    check("rst_werr", 32'(bus0.werr), 32'd0);
    check("rst_data", bus0.rsp_data,  32'd0);
    rst = 1'b0;

    access(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, d, mx, we, lat, hc);
    check("st_word_lat",   32'(lat), 32'd3);
    check("st_word_holds", 32'(hc),  32'd2);
    check("st_word_data",  d,        32'd0);
    check("st_word_werr",  32'(we),  32'd0);
    check("rsp_hold",      32'(bus0.hold), 32'd1);

    access(1'b0, 2'b10, 32'h10, 32'd0, d, mx, we, lat, hc);
    check("ld_word_lat",   32'(lat), 32'd3);
    check("ld_word_holds", 32'(hc),  32'd2);
    check("ld_word_data",  d,        32'hDEADBEEF);
    check("ld_word_mexc",  32'(mx),  32'd0);
    @(posedge clk); #1;
    check("idle_data", bus0.rsp_data, 32'd0);

    access(1'b1, 2'b00, 32'h12, 32'h000000AA, d, mx, we, lat, hc);
    access(1'b0, 2'b10, 32'h10, 32'd0, d, mx, we, lat, hc);
    check("ld_after_byte2", d, 32'hDEADAAEF);
    access(1'b1, 2'b00, 32'h13, 32'h12345677, d, mx, we, lat, hc);
    access(1'b0, 2'b10, 32'h10, 32'd0, d, mx, we, lat, hc);
    check("ld_after_byte3", d, 32'hDEADAA77);

    access(1'b1, 2'b10, 32'h20, 32'h00000000, d, mx, we, lat, hc);
    access(1'b1, 2'b01, 32'h20, 32'hFFFF1234, d, mx, we, lat, hc);
    access(1'b0, 2'b10, 32'h20, 32'd0, d, mx, we, lat, hc);
    check("ld_after_half0", d, 32'h12340000);
    access(1'b1, 2'b01, 32'h22, 32'h0000BEEF, d, mx, we, lat, hc);
    access(1'b0, 2'b11, 32'h20, 32'd0, d, mx, we, lat, hc);
    check("ld_after_half1", d, 32'h1234BEEF);

    access(1'b0, 2'b10, 32'h13, 32'd0, d, mx, we, lat, hc);
    check("misal_ld_mexc", 32'(mx), 32'd1);
    check("misal_ld_data", d,       32'd0);
    check("misal_ld_werr", 32'(we), 32'd0);
    access(1'b1, 2'b01, 32'h11, 32'h0000FFFF, d, mx, we, lat, hc);
    check("misal_st_werr", 32'(we), 32'd1);
    access(1'b0, 2'b10, 32'h10, 32'd0, d, mx, we, lat, hc);
    check("misal_st_nowr", d, 32'hDEADAA77);

    access(1'b1, 2'b10, 32'h0, 32'h55555555, d, mx, we, lat, hc);
    access(1'b1, 2'b10, 32'h400, 32'hCAFEF00D, d, mx, we, lat, hc);
    check("oor_st_mexc", 32'(mx), 32'd1);
    check("oor_st_werr", 32'(we), 32'd1);
    check("oor_st_data", d,       32'd0);
    access(1'b0, 2'b10, 32'h400, 32'd0, d, mx, we, lat, hc);
    check("oor_ld_mexc", 32'(mx), 32'd1);
    check("oor_ld_data", d,       32'd0);
    access(1'b0, 2'b10, 32'h0, 32'd0, d, mx, we, lat, hc);
    check("oor_no_alias", d, 32'h55555555);

    // Reset during WAIT of a store must abandon it
    access(1'b1, 2'b10, 32'h30, 32'h11111111, d, mx, we, lat, hc);
    @(posedge clk); #1;
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.req_size  = 2'b10;
    bus0.req_addr  = 32'h30;
    bus0.req_wdata = 32'h99999999;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    check("wait_hold", 32'(bus0.hold), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_hold", 32'(bus0.hold), 32'd1);
    check("abort_mds",  32'(bus0.mds),  32'd1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus0.mds === 1'b0) pulses++;
      @(posedge clk); #1;
    end
    check("abort_no_mds", 32'(pulses), 32'd0);
    access(1'b0, 2'b10, 32'h30, 32'd0, d, mx, we, lat, hc);
    check("abort_mem", d, 32'h11111111);

    // Zero wait states: back-to-back loads with req_valid held high
    @(posedge clk); #1;
    bus1.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("ws0_mds%0d", i),  32'(bus1.mds),  (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("ws0_hold%0d", i), 32'(bus1.hold), 32'd1);
    end
    bus1.req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
